lc3b_decode_seq: RTL and testbench

Registered decode stage for the pipelined LC-3b: it accepts one fetched instruction per handshake and emits a fully populated lc3b_control_word to the execute pipeline. Most opcodes decode to a single micro-op. Indirect opcodes (LDI, STI) are expanded into two micro-ops by an internal sequencer, which stalls fetch while the second micro-op is issued. It also supports backpressure, flush, and issue/bubble statistics counters.

---
 rtl/lc3b_decode_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_lc3b_decode_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_decode_seq.sv
// LC-3b registered decode stage: turns one fetched instruction into one
// control word, or into two control words for the indirect ops LDI/STI.

package lc3b_types_pkg;

    typedef enum logic [2:0] {
        alu_add   = 3'd0,
        alu_and   = 3'd1,
        alu_not   = 3'd2,
        alu_passa = 3'd3,
        alu_passb = 3'd4
    } lc3b_aluop;

    typedef enum logic [3:0] {
        op_br  = 4'h0, op_add = 4'h1, op_ldb = 4'h2, op_stb  = 4'h3,
        op_jsr = 4'h4, op_and = 4'h5, op_ldr = 4'h6, op_str  = 4'h7,
        op_rti = 4'h8, op_not = 4'h9, op_ldi = 4'hA, op_sti  = 4'hB,
        op_jmp = 4'hC, op_shf = 4'hD, op_lea = 4'hE, op_trap = 4'hF
    } lc3b_opcode;

    typedef struct packed {
        lc3b_opcode  opcode;
        logic [15:0] pc;
        lc3b_aluop   aluop;
        logic        load_reg;
        logic        load_cc;
        logic [1:0]  wbmux_sel;
        logic        sr2mux_sel;
        logic        addr1mux_sel;
        logic [1:0]  addr2mux_sel;
        logic        lshf;
        logic        dcacheR;
        logic        dcacheW;
        logic        storemux_sel;
        logic        br_op;
    } lc3b_control_word;

endpackage

module lc3b_decode_seq
    import lc3b_types_pkg::*;
#(
    parameter int ENABLE_INDIRECT = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      instr,
    input  logic [15:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output lc3b_control_word ctrl,
    output logic             uop_idx,
    output logic             uop_last,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic {RUN, IND2} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic             out_valid_nxt;
    lc3b_control_word ctrl_nxt;
    logic             uop_idx_nxt;
    logic             uop_last_nxt;
    logic             accept;

    // Fields shared by every recognised opcode: opcode, pc, pass-A ALU.
    function automatic lc3b_control_word base_word(input logic [15:0] ir, input logic [15:0] pc);
        lc3b_control_word w;
        w        = '0;
        w.opcode = lc3b_opcode'(ir[15:12]);
        w.pc     = pc;
        w.aluop  = alu_passa;
        return w;
    endfunction

    function automatic logic is_indirect(input logic [15:0] ir);
        return (ENABLE_INDIRECT != 0) &&
               ((ir[15:12] == op_ldi) || (ir[15:12] == op_sti));
    endfunction

    // Single micro-op decode; anything unrecognised collapses to all-zero.
    function automatic lc3b_control_word decode_single(input logic [15:0] ir, input logic [15:0] pc);
        lc3b_control_word w;
        w = base_word(ir, pc);
        case (ir[15:12])
            op_add, op_and: begin
                w.aluop      = (ir[15:12] == op_add) ? alu_add : alu_and;
                w.load_reg   = 1'b1;
                w.load_cc    = 1'b1;
                w.wbmux_sel  = 2'b11;
                w.sr2mux_sel = ir[5];
            end
            op_not: begin
                w.aluop     = alu_not;
                w.load_reg  = 1'b1;
                w.load_cc   = 1'b1;
                w.wbmux_sel = 2'b11;
            end
            op_ldr: begin
                w.addr1mux_sel = 1'b1;
                w.addr2mux_sel = 2'b01;
                w.lshf         = 1'b1;
                w.dcacheR      = 1'b1;
                w.wbmux_sel    = 2'b01;
                w.load_reg     = 1'b1;
                w.load_cc      = 1'b1;
            end
            op_str: begin
                w.addr1mux_sel = 1'b1;
                w.addr2mux_sel = 2'b01;
                w.lshf         = 1'b1;
                w.storemux_sel = 1'b1;
                w.dcacheW      = 1'b1;
                w.aluop        = alu_passb;
            end
            op_br: begin
                w.addr2mux_sel = 2'b10;
                w.lshf         = 1'b1;
                w.br_op        = 1'b1;
            end
            op_lea: begin
                w.addr2mux_sel = 2'b10;
                w.lshf         = 1'b1;
                w.wbmux_sel    = 2'b10;
                w.load_reg     = 1'b1;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    // First half of LDI/STI: fetch the pointer word, no architectural writes.
    function automatic lc3b_control_word uop0_word(input logic [15:0] ir, input logic [15:0] pc);
        lc3b_control_word w;
        w              = base_word(ir, pc);
        w.addr1mux_sel = 1'b1;
        w.addr2mux_sel = 2'b01;
        w.lshf         = 1'b1;
        w.dcacheR      = 1'b1;
        return w;
    endfunction

    // Second half, rebuilt from the held first half so no instruction copy is kept.
    function automatic lc3b_control_word uop1_word(input lc3b_control_word prev);
        lc3b_control_word w;
        w        = '0;
        w.opcode = prev.opcode;
        w.pc     = prev.pc;
        w.aluop  = alu_passa;
        if (prev.opcode == op_ldi) begin
            w.dcacheR   = 1'b1;
            w.wbmux_sel = 2'b01;
            w.load_reg  = 1'b1;
            w.load_cc   = 1'b1;
        end else begin
            w.dcacheW      = 1'b1;
            w.storemux_sel = 1'b1;
            w.aluop        = alu_passb;
        end
        return w;
    endfunction

    assign in_ready = (state == RUN) && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Next state and next output register contents.
    always_comb begin
        state_nxt     = state;
        out_valid_nxt = out_valid;
        ctrl_nxt      = ctrl;
        uop_idx_nxt   = uop_idx;
        uop_last_nxt  = uop_last;
        if (flush) begin
            out_valid_nxt = 1'b0;
            state_nxt     = RUN;
            uop_idx_nxt   = 1'b0;
            uop_last_nxt  = 1'b0;
        end else if (state == IND2) begin
            if (out_ready) begin
                ctrl_nxt      = uop1_word(ctrl);
                out_valid_nxt = 1'b1;
                uop_idx_nxt   = 1'b1;
                uop_last_nxt  = 1'b1;
                state_nxt     = RUN;
            end
        end else if (accept) begin
            out_valid_nxt = 1'b1;
            uop_idx_nxt   = 1'b0;
            if (is_indirect(instr)) begin
                ctrl_nxt     = uop0_word(instr, in_pc);
                uop_last_nxt = 1'b0;
                state_nxt    = IND2;
            end else begin
                ctrl_nxt     = decode_single(instr, in_pc);
                uop_last_nxt = 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end
    end

    // State and output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            out_valid <= 1'b0;
            ctrl      <= '0;
            uop_idx   <= 1'b0;
            uop_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= out_valid_nxt;
            ctrl      <= ctrl_nxt;
            uop_idx   <= uop_idx_nxt;
            uop_last  <= uop_last_nxt;
        end
    end

    // Issue and bubble statistics, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && out_ready) issue_cnt  <= issue_cnt + CNT_ONE;
            if (!out_valid && !flush)   bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_lc3b_decode_seq.sv
// Bench for lc3b_decode_seq: directed scenarios plus random traffic, with a
// transaction-level model for an indirect-enabled and an indirect-disabled DUT.
module tb_lc3b_decode_seq;
    import lc3b_types_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, flush, out_ready;
    logic [15:0] instr, in_pc;

    logic             rdy   [2];
    logic             vld   [2];
    lc3b_control_word cw    [2];
    logic             idx   [2];
    logic             last  [2];
    logic [15:0]      issue [2];
    logic [15:0]      bub   [2];

    lc3b_decode_seq #(.ENABLE_INDIRECT(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .instr(instr), .in_pc(in_pc), .flush(flush), .out_valid(vld[0]),
        .out_ready(out_ready), .ctrl(cw[0]), .uop_idx(idx[0]), .uop_last(last[0]),
        .issue_cnt(issue[0]), .bubble_cnt(bub[0]));

    lc3b_decode_seq #(.ENABLE_INDIRECT(0), .CNT_W(16)) dut_noind (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .instr(instr), .in_pc(in_pc), .flush(flush), .out_valid(vld[1]),
        .out_ready(out_ready), .ctrl(cw[1]), .uop_idx(idx[1]), .uop_last(last[1]),
        .issue_cnt(issue[1]), .bubble_cnt(bub[1]));

    int errors = 0;
    int checks = 0;
    logic go = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected control word from the instruction-set rules; uop selects which
    // half of an indirect op is wanted.
    function automatic lc3b_control_word exp_word(input logic [15:0] ir, input logic [15:0] pc,
                                                  input int uop, input int ei);
        lc3b_control_word w;
        logic [3:0] op;
        op       = ir[15:12];
        w        = '0;
        w.opcode = lc3b_opcode'(op);
        w.pc     = pc;
        w.aluop  = alu_passa;
        if (op == 4'h1 || op == 4'h5) begin
            w.aluop = (op == 4'h1) ? alu_add : alu_and;
            w.load_reg = 1; w.load_cc = 1; w.wbmux_sel = 2'd3; w.sr2mux_sel = ir[5];
        end else if (op == 4'h9) begin
            w.aluop = alu_not; w.load_reg = 1; w.load_cc = 1; w.wbmux_sel = 2'd3;
        end else if (op == 4'h6) begin
            w.addr1mux_sel = 1; w.addr2mux_sel = 2'd1; w.lshf = 1; w.dcacheR = 1;
            w.wbmux_sel = 2'd1; w.load_reg = 1; w.load_cc = 1;
        end else if (op == 4'h7) begin
            w.addr1mux_sel = 1; w.addr2mux_sel = 2'd1; w.lshf = 1; w.storemux_sel = 1;
            w.dcacheW = 1; w.aluop = alu_passb;
        end else if (op == 4'h0) begin
            w.addr2mux_sel = 2'd2; w.lshf = 1; w.br_op = 1;
        end else if (op == 4'hE) begin
            w.addr2mux_sel = 2'd2; w.lshf = 1; w.wbmux_sel = 2'd2; w.load_reg = 1;
        end else if ((op == 4'hA || op == 4'hB) && ei != 0) begin
            if (uop == 0) begin
                w.addr1mux_sel = 1; w.addr2mux_sel = 2'd1; w.lshf = 1; w.dcacheR = 1;
            end else if (op == 4'hA) begin
                w.dcacheR = 1; w.wbmux_sel = 2'd1; w.load_reg = 1; w.load_cc = 1;
            end else begin
                w.dcacheW = 1; w.storemux_sel = 1; w.aluop = alu_passb;
            end
        end else begin
            w = '0;
        end
        return w;
    endfunction

    typedef struct {
        logic             v;
        lc3b_control_word c;
        logic             idx;
        logic             last;
        logic             pend;
        logic [15:0]      pir;
        logic [15:0]      ppc;
        logic [15:0]      issue;
        logic [15:0]      bubble;
    } mdl_t;
    mdl_t m [2];

    // Reference model: advance both instances by one clock using the inputs
    // presented for that edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int   ei;
            logic mrdy;
            ei = (k == 0) ? 1 : 0;
            if (!rst_n) begin
                m[k].v = 0; m[k].c = '0; m[k].idx = 0; m[k].last = 0; m[k].pend = 0;
                m[k].pir = 0; m[k].ppc = 0; m[k].issue = 0; m[k].bubble = 0;
            end else begin
                mrdy = !m[k].pend && !flush && (!m[k].v || out_ready);
                if (m[k].v && out_ready) m[k].issue = m[k].issue + 16'd1;
                if (!m[k].v && !flush)   m[k].bubble = m[k].bubble + 16'd1;
                if (flush) begin
                    m[k].v = 0; m[k].pend = 0; m[k].idx = 0;
                end else if (m[k].pend) begin
                    if (out_ready) begin
                        m[k].c = exp_word(m[k].pir, m[k].ppc, 1, ei);
                        m[k].idx = 1; m[k].last = 1; m[k].pend = 0; m[k].v = 1;
                    end
                end else if (in_valid && mrdy) begin
                    m[k].v   = 1;
                    m[k].idx = 0;
                    m[k].c   = exp_word(instr, in_pc, 0, ei);
                    if (ei != 0 && (instr[15:12] == 4'hA || instr[15:12] == 4'hB)) begin
                        m[k].last = 0; m[k].pend = 1; m[k].pir = instr; m[k].ppc = in_pc;
                    end else begin
                        m[k].last = 1;
                    end
                end else if (m[k].v && out_ready) begin
                    m[k].v = 0;
                end
            end
        end
    end

    // Compare both DUTs against the model every cycle, away from the edge.
    always @(negedge clk) begin
        if (go) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m%0d out_valid", k), 64'(vld[k]), 64'(m[k].v));
                chk($sformatf("m%0d in_ready", k), 64'(rdy[k]),
                    64'(!m[k].pend && !flush && (!m[k].v || out_ready)));
                chk($sformatf("m%0d issue_cnt", k), 64'(issue[k]), 64'(m[k].issue));
                chk($sformatf("m%0d bubble_cnt", k), 64'(bub[k]), 64'(m[k].bubble));
                if (m[k].v) begin
                    chk($sformatf("m%0d ctrl", k), 64'(cw[k]), 64'(m[k].c));
                    chk($sformatf("m%0d uop_idx", k), 64'(idx[k]), 64'(m[k].idx));
                    chk($sformatf("m%0d uop_last", k), 64'(last[k]), 64'(m[k].last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  optab [12];
    logic [15:0] b0;
    logic [15:0] r;

    initial begin
        optab = '{4'h0, 4'h1, 4'h5, 4'h9, 4'h6, 4'h7, 4'hE, 4'hA, 4'hB, 4'hD, 4'h4, 4'hF};
        rst_n = 0; in_valid = 0; flush = 0; out_ready = 1; instr = 0; in_pc = 0;
        tick(); tick();
        go = 1;
        @(negedge clk);
        chk("rst out_valid", 64'(vld[0]), 64'd0);
        chk("rst ctrl", 64'(cw[0]), 64'd0);
        chk("rst uop_idx", 64'(idx[0]), 64'd0);
        chk("rst uop_last", 64'(last[0]), 64'd0);
        chk("rst issue", 64'(issue[0]), 64'd0);
        chk("rst bubble", 64'(bub[0]), 64'd0);
        tick();
        rst_n = 1;

        // ADD R1,R2,#5
        in_valid = 1; instr = 16'h12A5; in_pc = 16'h3000; out_ready = 1;
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("add valid", 64'(vld[0]), 64'd1);
        chk("add aluop", 64'(cw[0].aluop), 64'(alu_add));
        chk("add sr2mux", 64'(cw[0].sr2mux_sel), 64'd1);
        chk("add wbmux", 64'(cw[0].wbmux_sel), 64'd3);
        chk("add load_reg", 64'(cw[0].load_reg), 64'd1);
        chk("add load_cc", 64'(cw[0].load_cc), 64'd1);
        chk("add pc", 64'(cw[0].pc), 64'h3000);
        chk("add last", 64'(last[0]), 64'd1);
        tick();
        chk("add issue", 64'(issue[0]), 64'd1);

        // LDI held for three cycles
        in_valid = 1; instr = 16'hA242; in_pc = 16'h3002; out_ready = 0;
        tick();
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ldi0 dcacheR", 64'(cw[0].dcacheR), 64'd1);
            chk("ldi0 load_reg", 64'(cw[0].load_reg), 64'd0);
            chk("ldi0 idx", 64'(idx[0]), 64'd0);
            chk("ldi0 in_ready", 64'(rdy[0]), 64'd0);
            tick();
        end
        out_ready = 1;
        tick();
        @(negedge clk);
        chk("ldi1 idx", 64'(idx[0]), 64'd1);
        chk("ldi1 last", 64'(last[0]), 64'd1);
        chk("ldi1 load_reg", 64'(cw[0].load_reg), 64'd1);
        chk("ldi1 load_cc", 64'(cw[0].load_cc), 64'd1);
        chk("ldi1 pc", 64'(cw[0].pc), 64'h3002);
        chk("ldi1 in_ready", 64'(rdy[0]), 64'd1);
        chk("ldi1 issue", 64'(issue[0]), 64'd2);
        tick();

        // STI flushed while uop0 is held
        in_valid = 1; instr = 16'hB242; in_pc = 16'h3004; out_ready = 0;
        tick();
        in_valid = 0;
        tick();
        flush = 1;
        tick();
        flush = 0; out_ready = 1;
        @(negedge clk);
        chk("sti flush valid", 64'(vld[0]), 64'd0);
        chk("sti flush idx", 64'(idx[0]), 64'd0);
        chk("sti flush in_ready", 64'(rdy[0]), 64'd1);
        tick(); tick();
        chk("sti no uop1", 64'(vld[0]), 64'd0);

        // SHF is unknown; LDI is unknown on the non-indirect instance
        in_valid = 1; instr = 16'hD123; in_pc = 16'h1234;
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("shf ctrl", 64'(cw[0]), 64'd0);
        chk("shf valid", 64'(vld[0]), 64'd1);
        chk("shf last", 64'(last[0]), 64'd1);
        tick();
        in_valid = 1; instr = 16'hA242; in_pc = 16'h1234;
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("noind ldi ctrl", 64'(cw[1]), 64'd0);
        chk("noind ldi valid", 64'(vld[1]), 64'd1);
        chk("noind ldi last", 64'(last[1]), 64'd1);
        tick(); tick();

        // AND, NOT, BR back to back, then idle
        in_valid = 1; instr = 16'h5241; in_pc = 16'h4000;
        tick();
        instr = 16'h927F; in_pc = 16'h4002;
        @(negedge clk);
        chk("and aluop", 64'(cw[0].aluop), 64'(alu_and));
        b0 = bub[0];
        tick();
        instr = 16'h0E05; in_pc = 16'h4004;
        @(negedge clk);
        chk("not aluop", 64'(cw[0].aluop), 64'(alu_not));
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("br br_op", 64'(cw[0].br_op), 64'd1);
        chk("b2b bubble", 64'(bub[0]), 64'(b0));
        repeat (5) tick();
        chk("idle bubble", 64'(bub[0]), 64'(b0 + 16'd4));

        // Reset while in IND2
        in_valid = 1; instr = 16'hA242; in_pc = 16'h5000; out_ready = 0;
        tick();
        in_valid = 0;
        tick();
        rst_n = 0;
        tick();
        rst_n = 1; out_ready = 1;
        @(negedge clk);
        chk("rst2 valid", 64'(vld[0]), 64'd0);
        chk("rst2 ctrl", 64'(cw[0]), 64'd0);
        chk("rst2 issue", 64'(issue[0]), 64'd0);
        chk("rst2 bubble", 64'(bub[0]), 64'd0);
        chk("rst2 in_ready", 64'(rdy[0]), 64'd1);
        tick(); tick();
        chk("rst2 no uop1", 64'(vld[0]), 64'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r         = 16'($urandom);
            rst_n     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            instr     = {optab[$urandom_range(0, 11)], r[11:0]};
            in_pc     = 16'($urandom);
            tick();
        end
        rst_n = 1; flush = 0; in_valid = 0;
        tick();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
